mux_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 select-driven output channel among four requesters. It owns the select lines of the channel multiplexer and a one-hot grant vector. It hands the channel to one requester at a time for a burst bounded by a `last` marker or a beat limit. It sits directly upstream of the channel datapath and is its only source of select values.

---
 rtl/mux_arbiter_pkg.sv | 12 +
 rtl/mux_arbiter_rr_pick.sv | 31 +++
 rtl/mux_arbiter.sv | 103 ++++++++++
 tb/tb_mux_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// rtl/mux_arbiter_pkg.sv - shared constants for the round-robin channel arbiter
package mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef logic state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rtl/mux_arbiter_rr_pick.sv - combinational round-robin picker starting after ptr
module rr_pick
    import mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        cand   = '0;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Offset NUM_REQ wraps to ptr itself, so the last served index is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (found) begin
            onehot = NUM_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin arbiter owning the 4:1 channel select and grant
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic               busy
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_inc;
    logic               grant_end;

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign out_valid = (|gnt_q) && req[sel_q];
    assign xfer      = out_valid && out_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    // A dropped request ends the grant without a beat; last and limit only on accepted beats.
    assign grant_end = !req[sel_q] || (xfer && (last[sel_q] || (cnt_inc == HOLD_MAX_C)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= 2'b11;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                state_d = ST_GRANT;
            end
        end else begin
            if (grant_end) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        gnt_d = gnt_q;
        sel_d = sel_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                gnt_d = pick_onehot;
                sel_d = pick_idx;
                cnt_d = '0;
            end
        end else begin
            if (grant_end) begin
                ptr_d = sel_q;
                gnt_d = '0;
                cnt_d = '0;
            end else if (xfer) begin
                cnt_d = cnt_inc;
            end
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter
module tb_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic       busy;

    int checks;
    int errors;

    mux_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        #12;
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state gnt=%b sel=%0d busy=%b ov=%b want 0000/0/0/0", gnt, sel, busy, out_valid);
        end
        checks++;
        if (dut.ptr_q !== 2'b11) begin
            errors++;
            $display("FAIL reset_ptr got=%0d want 3", dut.ptr_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            checks++;
            if (gnt !== exp_g || sel !== 2'(k % 4) || busy !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_grant k=%0d gnt=%b sel=%0d busy=%b ov=%b want %b/%0d/1/1",
                         k, gnt, sel, busy, out_valid, exp_g, k % 4);
            end
            step();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rotation_idle k=%0d gnt=%b busy=%b want 0000/0", k, gnt, busy);
            end
        end
        req = 4'b0000; last = 4'b0000;
    endtask

    task automatic test_last_burst();
        req = 4'b0100; last = 4'b0000;
        for (int b = 0; b < 3; b++) begin
            step();
            if (b == 2) last = 4'b0100;
            checks++;
            if (gnt !== 4'b0100 || sel !== 2'd2) begin
                errors++;
                $display("FAIL last_burst_beat b=%0d gnt=%b sel=%0d want 0100/2", b, gnt, sel);
            end
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || dut.ptr_q !== 2'd2 || sel !== 2'd2) begin
            errors++;
            $display("FAIL last_burst_end gnt=%b ptr=%0d sel=%0d want 0000/2/2", gnt, dut.ptr_q, sel);
        end
        req = 4'b0000; last = 4'b0000;
    endtask

    task automatic test_hold_max_and_stall();
        req = 4'b0011; last = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL hold_first_pick gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
        for (int b = 1; b <= 3; b++) begin
            step();
            checks++;
            if (gnt !== 4'b0001 || dut.cnt_q !== 3'(b)) begin
                errors++;
                $display("FAIL hold_count b=%0d gnt=%b cnt=%0d want 0001/%0d", b, gnt, dut.cnt_q, b);
            end
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || dut.cnt_q !== 3'd0 || dut.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL hold_limit_end gnt=%b cnt=%0d ptr=%0d want 0000/0/0", gnt, dut.cnt_q, dut.ptr_q);
        end
        step();
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            errors++;
            $display("FAIL hold_next_grant gnt=%b sel=%0d want 0010/1", gnt, sel);
        end
        step();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            checks++;
            if (gnt !== 4'b0010 || sel !== 2'd1 || dut.cnt_q !== 3'd1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_frozen s=%0d gnt=%b sel=%0d cnt=%0d ov=%b want 0010/1/1/1",
                         s, gnt, sel, dut.cnt_q, out_valid);
            end
        end
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (gnt !== 4'b0010 || dut.cnt_q !== 3'd3) begin
            errors++;
            $display("FAIL stall_resume gnt=%b cnt=%0d want 0010/3", gnt, dut.cnt_q);
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || dut.ptr_q !== 2'd1) begin
            errors++;
            $display("FAIL stall_complete gnt=%b ptr=%0d want 0000/1", gnt, dut.ptr_q);
        end
        req = 4'b0000;
    endtask

    task automatic test_drop_request();
        req = 4'b1000; last = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            errors++;
            $display("FAIL drop_grant gnt=%b sel=%0d want 1000/3", gnt, sel);
        end
        step();
        req = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.cnt_q !== 3'd1) begin
            errors++;
            $display("FAIL drop_valid ov=%b cnt=%0d want 0/1", out_valid, dut.cnt_q);
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || dut.ptr_q !== 2'd3) begin
            errors++;
            $display("FAIL drop_end gnt=%b busy=%b ptr=%0d want 0000/0/3", gnt, busy, dut.ptr_q);
        end
        req = 4'b1001;
        step();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL drop_next_from_0 gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
    endtask

    task automatic test_reset_mid_grant();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset gnt=%b sel=%0d busy=%b ov=%b want 0000/0/0/0", gnt, sel, busy, out_valid);
        end
        req = 4'b1001;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_grant gnt=%b sel=%0d busy=%b want 0001/0/1", gnt, sel, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation();
        test_last_burst();
        test_hold_max_and_stall();
        test_drop_request();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
